// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between the CPU MEM stage and a
//   DMA/debug loader. The CPU wins by default; after MAX_WAIT consecutive
//   cycles in which the DMA asked and lost, the DMA gets one forced grant.
//   The memory sees the winner's request combinationally, and read data is
//   registered and returned to the winner one cycle after its grant.
//
// Ports
//   clk, rst                 clock (rising edge) and async active-high reset
//   cpu_req/we/addr/wdata    CPU request
//   cpu_stall                CPU requested but was not granted this cycle
//   cpu_rvalid/cpu_rdata     CPU read response (one cycle after grant)
//   dma_req/we/addr/wdata    DMA request
//   dma_gnt                  DMA granted this cycle
//   dma_rvalid/dma_rdata     DMA read response (one cycle after grant)
//   mem_addr/wdata/we/re     memory drive (all zero when idle or in reset)
//   mem_rdata                combinational read data from the memory
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {NORMAL, FORCE_DMA} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              force_dma;
  logic              dma_win;
  logic              cpu_win;
  logic              cpu_rvalid_p1;
  logic              dma_rvalid_p1;
  logic [DATA_W-1:0] cpu_rdata_p1;
  logic [DATA_W-1:0] dma_rdata_p1;

  // Lost-cycle counter increment that sticks at the last count instead of
  // wrapping back to zero.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= WAIT_LAST) ? WAIT_LAST : v + 4'd1;
  endfunction

  // Stage p0: arbitration and memory drive, same cycle as the request.
  // A forced grant only applies if the DMA is still asking; otherwise the
  // cycle falls back to normal CPU priority.
  assign force_dma = (state == FORCE_DMA) && dma_req;
  assign dma_win   = dma_req && (force_dma || !cpu_req);
  assign cpu_win   = cpu_req && !dma_win;

  assign dma_gnt   = dma_win;
  assign cpu_stall = cpu_req && !cpu_win;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (!rst) begin
      if (cpu_win) begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_re    = !cpu_we;
      end else if (dma_win) begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we    = dma_we;
        mem_re    = !dma_we;
      end
    end
  end

  // Stage p1: arbitration state and registered read responses.
  // The NORMAL->FORCE_DMA step happens on the MAX_WAIT-th lost cycle, so the
  // forced grant lands on the cycle right after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= NORMAL;
      wait_cnt      <= 4'd0;
      cpu_rvalid_p1 <= 1'b0;
      dma_rvalid_p1 <= 1'b0;
      cpu_rdata_p1  <= '0;
      dma_rdata_p1  <= '0;
    end else begin
      case (state)
        NORMAL:    state <= (dma_req && cpu_req && wait_cnt == WAIT_LAST) ? FORCE_DMA : NORMAL;
        FORCE_DMA: state <= NORMAL;
        default:   state <= NORMAL;
      endcase

      if (dma_req && !dma_win) wait_cnt <= sat_inc(wait_cnt);
      else                     wait_cnt <= 4'd0;

      cpu_rvalid_p1 <= cpu_win && !cpu_we;
      dma_rvalid_p1 <= dma_win && !dma_we;
      if (cpu_win && !cpu_we) cpu_rdata_p1 <= mem_rdata;
      if (dma_win && !dma_we) dma_rdata_p1 <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_p1;
  assign cpu_rdata  = cpu_rdata_p1;
  assign dma_rvalid = dma_rvalid_p1;
  assign dma_rdata  = dma_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Randomized and directed stimulus against a behavioural model of the
//   arbiter: the DMA wins when the CPU is idle or after MAX_WAIT consecutive
//   lost cycles; the memory is modelled as a word array.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we, mem_re;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory attached to the DUT (64 words); preload port used only in reset.
  logic [DATA_W-1:0] mem [64];
  logic              pl_en = 1'b0;
  logic [5:0]        pl_idx = '0;
  logic [DATA_W-1:0] pl_val = '0;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx] <= pl_val;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  // Reference model state
  logic [DATA_W-1:0] ref_mem [64];
  int                lost;
  logic              e_cv, e_dv;
  logic [DATA_W-1:0] e_cd, e_dd;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    lost = 0;
    e_cv = 1'b0; e_dv = 1'b0; e_cd = '0; e_dd = '0;
  endtask

  task automatic set_in(input logic cr, input logic cw, input int ca, input logic [DATA_W-1:0] cd,
                        input logic dr, input logic dw, input int da, input logic [DATA_W-1:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ADDR_W'(ca); cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = ADDR_W'(da); dma_wdata = dd;
  endtask

  // One clock of traffic: check the same-cycle decisions at the falling
  // edge, advance the model, then check the registered responses.
  // exp_gnt < 0 means no extra directed expectation on dma_gnt.
  task automatic step(input int exp_gnt);
    logic dw, cw;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    logic ewe;
    @(negedge clk);
    dw = dma_req && (!cpu_req || lost >= MAX_WAIT);
    cw = cpu_req && !dw;
    ea = cw ? cpu_addr : (dw ? dma_addr : '0);
    ed = cw ? cpu_wdata : (dw ? dma_wdata : '0);
    ewe = cw ? cpu_we : (dw ? dma_we : 1'b0);
    chk("dma_gnt", dma_gnt, dw);
    chk("cpu_stall", cpu_stall, cpu_req && !cw);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    chk("mem_we", mem_we, ewe);
    chk("mem_re", mem_re, (cw || dw) && !ewe);
    if (exp_gnt >= 0) chk("dir_gnt", dma_gnt, exp_gnt[0]);
    e_cv = cw && !cpu_we;
    e_dv = dw && !dma_we;
    if (e_cv) e_cd = ref_mem[cpu_addr[7:2]];
    if (e_dv) e_dd = ref_mem[dma_addr[7:2]];
    if (cw && cpu_we) ref_mem[cpu_addr[7:2]] = cpu_wdata;
    if (dw && dma_we) ref_mem[dma_addr[7:2]] = dma_wdata;
    if (dma_req && !dw) lost = (lost < MAX_WAIT) ? lost + 1 : MAX_WAIT;
    else                lost = 0;
    @(posedge clk); #1;
    chk("cpu_rvalid", cpu_rvalid, e_cv);
    chk("cpu_rdata", cpu_rdata, e_cd);
    chk("dma_rvalid", dma_rvalid, e_dv);
    chk("dma_rdata", dma_rdata, e_dd);
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, '0, 0, 0, 0, '0);
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'hDEADBEEF;
    // Preload memory while in reset
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 6'(i); pl_val = ref_mem[i];
    end
    @(negedge clk); pl_en = 1'b0;
    // Reset state
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dma_rvalid", dma_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_mem_re", mem_re, 0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("idle_gnt", dma_gnt, 0);
    chk("idle_stall", cpu_stall, 0);
    chk("idle_mem_addr", mem_addr, 0);
    @(posedge clk); #1;

    // CPU-only read of 0x10
    set_in(1, 0, 'h10, '0, 0, 0, 0, '0);
    step(0);
    chk("dir_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    set_in(0, 0, 0, '0, 0, 0, 0, '0);
    step(0);

    // DMA write 0x20 then CPU read 0x20
    set_in(0, 0, 0, '0, 1, 1, 'h20, 32'h12345678);
    step(1);
    set_in(1, 0, 'h20, '0, 0, 0, 0, '0);
    step(0);
    chk("dir_dma_wr_rd", cpu_rdata, 32'h12345678);

    // Idle: both requests low
    set_in(0, 0, 0, '0, 0, 0, 0, '0);
    for (int i = 0; i < 10; i++) step(0);

    // Contention: forced DMA grant every 5th cycle
    for (int i = 0; i < 15; i++) begin
      set_in(1, 0, 4 * $urandom_range(0, 63), '0, 1, 0, 4 * $urandom_range(0, 63), '0);
      step((i % 5 == 4) ? 1 : 0);
    end
    set_in(0, 0, 0, '0, 0, 0, 0, '0);
    step(0);

    // dma_req dropped after 3 lost cycles clears the wait count
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 'h10, '0, 1, 0, 'h20, '0);
      step(0);
    end
    set_in(1, 0, 'h10, '0, 0, 0, 0, '0);
    step(0);
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 'h10, '0, 1, 0, 'h20, '0);
      step((i == 4) ? 1 : 0);
    end

    // Async reset between a granted CPU read edge and the next edge
    set_in(1, 0, 'h10, '0, 0, 0, 0, '0);
    step(0);
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu_rvalid", cpu_rvalid, 0);
    chk("arst_cpu_rdata", cpu_rdata, 0);
    set_in(1, 1, 'h10, 32'hBAD0BAD0, 1, 1, 'h14, 32'hBAD1BAD1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("arst_mem_we", mem_we, 0);
      chk("arst_mem_addr", mem_addr, 0);
    end
    set_in(0, 0, 0, '0, 0, 0, 0, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4 * $urandom_range(0, 63), $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 4 * $urandom_range(0, 63), $urandom);
      step(-1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
